// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the serial ADC capture front-end.
package adc_pkg;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int SAMPLE_W   = 12;

  typedef enum logic [2:0] {
    ADC_IDLE,
    ADC_SETUP,
    ADC_SHIFT,
    ADC_DONE,
    ADC_WAIT
  } adc_state_e;
endpackage

// File: rtl/adc_sclk_div.sv
// SCLK half-period timer: pulses fall_tick_o / rise_tick_o on the edge where
// the registered SCLK should toggle. The phase restarts high on clr_i.
module adc_sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [HW-1:0] half_q;
  logic          hi_q;
  logic          wrap;

  assign wrap        = en_i && !clr_i && (half_q == HW'(CLK_DIV - 1));
  assign fall_tick_o = wrap && hi_q;
  assign rise_tick_o = wrap && !hi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      half_q <= '0;
      hi_q   <= 1'b1;
    end else if (clr_i) begin
      half_q <= '0;
      hi_q   <= 1'b1;
    end else if (en_i) begin
      if (wrap) begin
        half_q <= '0;
        hi_q   <= !hi_q;
      end else begin
        half_q <= half_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/adc_spi_capture.sv
// Drives a 16-SCLK serial ADC frame once per SAMPLE_PERIOD and presents the
// 12-bit result with a one-cycle ready_o strobe.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 78,
  parameter int QUIET_CYC     = 4
) (
  input  logic                clk_78MHz,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                adc_sdata_i,
  output logic                adc_cs_n_o,
  output logic                adc_sclk_o,
  output logic [SAMPLE_W-1:0] data_o,
  output logic                ready_o,
  output logic                frame_err_o
);
  localparam int PW = $clog2(SAMPLE_PERIOD);

  if (CLK_DIV < 1 || SAMPLE_PERIOD < 32 * CLK_DIV + 1 + QUIET_CYC) begin : g_bad_cfg
    $fatal(1, "adc_spi_capture: SAMPLE_PERIOD too short for CLK_DIV and QUIET_CYC");
  end

  adc_state_e            state_q;
  logic [PW-1:0]         per_q;
  logic [4:0]            bit_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic                  cs_n_q, sclk_q, ready_q, ferr_q;
  logic [SAMPLE_W-1:0]   data_q;
  logic                  per_wrap, start, div_en, div_clr, rise_tick, fall_tick;

  assign per_wrap = (per_q == PW'(SAMPLE_PERIOD - 1));
  assign start    = en_i && (state_q == ADC_IDLE || (state_q == ADC_WAIT && per_wrap));
  assign div_en   = (state_q == ADC_SETUP) || (state_q == ADC_SHIFT);
  assign div_clr  = start || !en_i;

  adc_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk_i       (clk_78MHz),
    .rst_ni      (rst_n),
    .en_i        (div_en),
    .clr_i       (div_clr),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_ff @(posedge clk_78MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ADC_IDLE;
      per_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (!en_i) begin
        // Abort: the partial frame is dropped, data_q keeps the last sample.
        state_q <= ADC_IDLE;
        per_q   <= '0;
        bit_q   <= '0;
        shreg_q <= '0;
        cs_n_q  <= 1'b1;
        sclk_q  <= 1'b1;
      end else begin
        per_q <= (state_q == ADC_IDLE || per_wrap) ? '0 : per_q + 1'b1;
        case (state_q)
          ADC_IDLE: begin
            state_q <= ADC_SETUP;
            cs_n_q  <= 1'b0;
          end
          ADC_SETUP: if (fall_tick) begin
            sclk_q  <= 1'b0;
            state_q <= ADC_SHIFT;
          end
          ADC_SHIFT: begin
            if (fall_tick) sclk_q <= 1'b0;
            if (rise_tick) begin
              sclk_q  <= 1'b1;
              shreg_q <= {shreg_q[FRAME_BITS-2:0], adc_sdata_i};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 5'(FRAME_BITS - 1)) state_q <= ADC_DONE;
            end
          end
          ADC_DONE: begin
            cs_n_q  <= 1'b1;
            data_q  <= shreg_q[SAMPLE_W-1:0];
            ready_q <= 1'b1;
            ferr_q  <= |shreg_q[FRAME_BITS-1 -: LEAD_ZEROS];
            bit_q   <= '0;
            state_q <= ADC_WAIT;
          end
          ADC_WAIT: if (per_wrap) begin
            state_q <= ADC_SETUP;
            cs_n_q  <= 1'b0;
          end
          default: state_q <= ADC_IDLE;
        endcase
      end
    end
  end

  assign adc_cs_n_o  = cs_n_q;
  assign adc_sclk_o  = sclk_q;
  assign data_o      = data_q;
  assign ready_o     = ready_q;
  assign frame_err_o = ferr_q;
endmodule

// File: doc/adc_spi_capture.md
# adc_spi_capture

Front-end stage that drives a 12-bit serial ADC (16-SCLK frame: 4 leading zeros + 12 data bits, MSB first, data changes on SCLK falling edge) and delivers parallel samples to the FIR filter stage. It generates chip-select and serial clock from the 78 MHz system clock, runs one conversion per programmable sample period, and presents each completed word on `data_o` together with a one-cycle `ready_o` strobe that connects directly to the FIR's `data_in` / `ready_i`.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCLK half-period in `clk_78MHz` cycles (2 gives 19.5 MHz SCLK); minimum 1.
- `SAMPLE_PERIOD`, default 78: clock cycles between conversion starts (1 MSPS).
- `QUIET_CYC`, default 4: minimum cycles `adc_cs_n_o` stays high between frames.
- Elaboration-time check: `SAMPLE_PERIOD >= 32*CLK_DIV + 1 + QUIET_CYC`; violation is a fatal error.

Ports:
- `clk_78MHz` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en_i` in 1: run enable, level.
- `adc_sdata_i` in 1: ADC serial data.
- `adc_cs_n_o` out 1: ADC chip select, active-low, registered.
- `adc_sclk_o` out 1: ADC serial clock, idles high, registered.
- `data_o` out 12: last completed sample, unsigned, held until next `ready_o`.
- `ready_o` out 1: one-cycle strobe, `data_o` valid in that cycle.
- `frame_err_o` out 1: one-cycle strobe with `ready_o` when any of the 4 leading bits read 1.

## Operation
- FSM states: IDLE, SETUP, SHIFT, DONE, WAIT.
- IDLE: `cs_n`=1, `sclk`=1, period counter held at 0. Leave to SETUP on the first cycle with `en_i`=1.
- SETUP: `cs_n`=0, `sclk`=1 for `CLK_DIV` cycles, then go to SHIFT.
- SHIFT: 16 SCLK periods, each `CLK_DIV` cycles low followed by `CLK_DIV` cycles high. On the edge that drives `sclk` high, shift `adc_sdata_i` into a 16-bit register (MSB first). A 5-bit bit counter ends SHIFT after the 16th rising edge.
- DONE (1 cycle): `cs_n`=1, `sclk`=1, `data_o` ← `shreg[11:0]`, `ready_o`=1, `frame_err_o` = OR of `shreg[15:12]`.
- WAIT: wait until the free-running period counter (0..`SAMPLE_PERIOD`−1, started at SETUP entry) wraps, then enter SETUP. Conversion starts are therefore exactly `SAMPLE_PERIOD` cycles apart.
- `en_i` low in any state: on the next edge go to IDLE, `cs_n`=1, `sclk`=1, and clear the bit counter, period counter and shift register. A partial frame is discarded with no `ready_o`. `data_o` keeps its last value.
- `en_i` re-asserted: a fresh frame starts from SETUP. There is no stale strobe.
- Reset values (async, `rst_n`=0): `adc_cs_n_o`=1, `adc_sclk_o`=1, `data_o`=0, `ready_o`=0, `frame_err_o`=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame immediately.

## Timing
- Let edge k be the edge where `cs_n` goes low. SCLK falling edge n (n=1..16) occurs at k+(2n−1)·`CLK_DIV`; rising edge n occurs at k+2n·`CLK_DIV`.
- Last sample is captured at k+32·`CLK_DIV`. `ready_o`=1 and `cs_n`=1 in the cycle after k+32·`CLK_DIV`+1. Default latency: 65 cycles from `cs_n` fall to `ready_o`.
- Next `cs_n` fall at k+`SAMPLE_PERIOD`. `cs_n` high time = `SAMPLE_PERIOD` − 32·`CLK_DIV` − 1 (13 cycles at defaults).
- `ready_o` is high for one full cycle, so the FIR's falling-edge sampling sees it exactly once.
- `data_o` changes only in the `ready_o` cycle.

## Structure
- Shared package `adc_pkg` holds:
  - `FRAME_BITS`=16, `LEAD_ZEROS`=4, `SAMPLE_W`=12;
  - the FSM state enum (`ADC_IDLE`, `ADC_SETUP`, `ADC_SHIFT`, `ADC_DONE`, `ADC_WAIT`).
- Sub-module `adc_sclk_div` (one instance): half-period counter that emits `rise_tick` / `fall_tick` pulses while enabled and is cleared on SETUP entry and on abort. The FSM, shift register and period counter stay in the top module.

## Test plan
- ADC model returns 0x0A5C with 4 leading zeros, defaults. Required: 16 SCLK rising edges per frame, `data_o`=0xA5C with `ready_o` pulse 65 cycles after `cs_n` fall, `frame_err_o`=0, next `cs_n` fall exactly 78 cycles after the previous one.
- Ramp 0x000..0xFFF over consecutive frames. Required: each `ready_o` carries the next value, no missed or duplicate strobes, one strobe per 78 cycles.
- Model drives leading bits 0b0100 with data 0x123. Required: `data_o`=0x123, `frame_err_o`=1 in the same cycle as `ready_o`.
- Drop `en_i` on the 8th SCLK rising edge. Required: `cs_n`=1 and `sclk`=1 on the next edge, no `ready_o`, `data_o` unchanged. Re-enable: a full frame follows with correct data.
- Assert `rst_n`=0 mid-SHIFT. Required: outputs go immediately (asynchronously) to `cs_n`=1, `sclk`=1, `data_o`=0, `ready_o`=0. After release with `en_i`=1, the first `ready_o` arrives 65 cycles after the first `cs_n` fall.
- `CLK_DIV`=1, `SAMPLE_PERIOD`=37, `QUIET_CYC`=4 (boundary). Required: frames back-to-back with 4 cycles of `cs_n` high and correct data. `SAMPLE_PERIOD`=36 fails elaboration.
